// File: rtl/sccb_pkg.sv
// Shared SCCB target definitions: FSM states, bus flag bytes and the default device address.
package sccb_pkg;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_DEV_ADDR = 4'd1,
        S_DEV_ACK  = 4'd2,
        S_SUB_ADDR = 4'd3,
        S_SUB_ACK  = 4'd4,
        S_WR_DATA  = 4'd5,
        S_WR_ACK   = 4'd6,
        S_RD_DATA  = 4'd7,
        S_RD_ACK   = 4'd8,
        S_IGNORE   = 4'd9
    } sccb_state_e;

    localparam logic [6:0] SCCB_DEF_DEV_ADDR = 7'h21;
    localparam logic [7:0] SCCB_WR_FLAG      = 8'h42;
    localparam logic [7:0] SCCB_RD_FLAG      = 8'h43;

endpackage

// File: rtl/sccb_line_sync.sv
// Synchronises raw SCL/SDA pads and detects SCL edges plus START/STOP conditions.
module sccb_line_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl,
    input  logic sda_in,
    output logic scl_s,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_prev_q;
    logic                   sda_prev_q;

    // Reset to the idle-high bus level so no edge is seen coming out of reset on an idle bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
        end
    end

    assign scl_s    = scl_sync_q[SYNC_STAGES-1];
    assign sda_s    = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise = scl_s & ~scl_prev_q;
    assign scl_fall = ~scl_s & scl_prev_q;

    // SCL must be high on both samples; an SDA change coincident with an SCL edge is a data bit.
    assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/sccb_target.sv
// SCCB/I2C target with register-file side interface; SDA driven open-drain only.
// Optional macro SCCB_AUTO_INC_EN enables register pointer auto-increment.
module sccb_target
    import sccb_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR    = SCCB_DEF_DEV_ADDR,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scl,
    input  logic        sda_in,
    output logic        sda_oe,
    output logic [7:0]  reg_addr,
    output logic [7:0]  reg_wdata,
    output logic        reg_wr_en,
    output logic        reg_rd_en,
    input  logic [7:0]  reg_rdata,
    output logic        busy,
    output logic [11:0] debug_out
);

    logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;

    sccb_line_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .scl      (scl),
        .sda_in   (sda_in),
        .scl_s    (scl_s),
        .sda_s    (sda_s),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start_det(start_det),
        .stop_det (stop_det)
    );

    sccb_state_e state_q, state_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        sda_oe_q, sda_oe_d;
    logic        busy_q, busy_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        wr_en_q, wr_en_d;
    logic        rd_load;
    logic [7:0]  byte_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            sda_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wr_en_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            sda_oe_q  <= sda_oe_d;
            busy_q    <= busy_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wr_en_q   <= wr_en_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        sda_oe_d  = sda_oe_q;
        busy_d    = busy_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wr_en_d   = 1'b0;
        rd_load   = 1'b0;
        byte_in   = {shift_q[6:0], sda_s};
`ifdef SCCB_AUTO_INC_EN
        // Bump the pointer the clk after the strobe so the strobe itself sees the old address.
        if (wr_en_q) begin
            addr_d = addr_q + 8'd1;
        end
`endif
        if (stop_det) begin
            state_d   = S_IDLE;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else if (start_det) begin
            state_d   = S_DEV_ADDR;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
        end else begin
            case (state_q)
                S_DEV_ADDR, S_SUB_ADDR, S_WR_DATA: begin
                    if (scl_rise) begin
                        shift_d = byte_in;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d = 4'd8;
                            if (state_q == S_DEV_ADDR) begin
                                if (byte_in[7:1] == DEV_ADDR) begin
                                    busy_d  = 1'b1;
                                    state_d = S_DEV_ACK;
                                end else begin
                                    state_d = S_IGNORE;
                                end
                            end else if (state_q == S_SUB_ADDR) begin
                                addr_d  = byte_in;
                                state_d = S_SUB_ACK;
                            end else begin
                                wdata_d = byte_in;
                                wr_en_d = 1'b1;
                                state_d = S_WR_ACK;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
                // bit_cnt 8: fall ending the byte starts the ACK; 9: fall ending the ACK bit.
                S_DEV_ACK, S_SUB_ACK, S_WR_ACK: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_oe_d  = 1'b1;
                            bit_cnt_d = 4'd9;
                        end else begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = '0;
                            if (state_q == S_DEV_ACK) begin
                                if (shift_q[0]) begin
                                    rd_load = 1'b1;
                                end else begin
                                    state_d = S_SUB_ADDR;
                                end
                            end else begin
                                state_d = S_WR_DATA;
                            end
                        end
                    end
                end
                S_RD_DATA: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = '0;
                            state_d   = S_RD_ACK;
                        end else begin
                            sda_oe_d  = ~shift_q[6];
                            shift_d   = {shift_q[6:0], 1'b0};
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
                S_RD_ACK: begin
                    if (scl_rise) begin
                        if (!sda_s) begin
                            bit_cnt_d = 4'd9;
`ifdef SCCB_AUTO_INC_EN
                            addr_d = addr_q + 8'd1;
`endif
                        end else begin
                            state_d = S_IGNORE;
                        end
                    end else if (scl_fall && bit_cnt_q == 4'd9) begin
                        rd_load = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        // bit_cnt counts bits already placed on SDA; the MSB goes out with the load.
        if (rd_load) begin
            shift_d   = reg_rdata;
            sda_oe_d  = ~reg_rdata[7];
            bit_cnt_d = 4'd1;
            state_d   = S_RD_DATA;
        end
    end

    assign sda_oe    = sda_oe_q;
    assign busy      = busy_q;
    assign reg_addr  = addr_q;
    assign reg_wdata = wdata_q;
    assign reg_wr_en = wr_en_q;
    assign reg_rd_en = rd_load & ~rst;
    assign debug_out = {state_q, bit_cnt_q, scl_s, sda_s, sda_oe_q, busy_q};

endmodule
